// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative compare unit: op encodings, FSM states,
// chunk relation type and small helpers to turn a relation into a result.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ = 3'b000;
  localparam logic [2:0] CMP_GE = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b011;
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

  typedef enum logic [1:0] {LT, EQ, GT} cmp_rel_t;

  // Ops 110 and 111 have no meaning and are reported via op_err.
  function automatic logic isIllegalOp(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

  // Turns the decided relation of a versus b into the requested predicate.
  function automatic logic evalOp(input logic [2:0] op, input cmp_rel_t rel);
    logic res;
    case (op)
      CMP_EQ:  res = (rel == EQ);
      CMP_GE:  res = (rel != LT);
      CMP_LE:  res = (rel != GT);
      CMP_GT:  res = (rel == GT);
      CMP_LT:  res = (rel == LT);
      CMP_NE:  res = (rel != EQ);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // One-hot {gt,eq,lt} view of a relation.
  function automatic logic [2:0] relFlags(input cmp_rel_t rel);
    return {rel == GT, rel == EQ, rel == LT};
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice of a and b.
// Setting invert_msb flips the slice MSB of both operands, which turns the
// unsigned compare of the top slice into a two's-complement compare.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output cmp_rel_t         rel
);

  logic [CHUNK-1:0] w_mask;
  logic [CHUNK-1:0] w_aAdj;
  logic [CHUNK-1:0] w_bAdj;

  // Apply the optional sign flip, then order the adjusted slices.
  always_comb begin
    w_mask = '0;
    w_mask[CHUNK-1] = invert_msb;
    w_aAdj = a ^ w_mask;
    w_bAdj = b ^ w_mask;
    if (w_aAdj > w_bAdj) begin
      rel = GT;
    end else if (w_aAdj < w_bAdj) begin
      rel = LT;
    end else begin
      rel = EQ;
    end
  end

endmodule

// File: rtl/cmp_iter_unit.sv
// Multi-cycle wide comparator: walks a/b one chunk per cycle from the most
// significant chunk down and stops as soon as a chunk pair differs.
// Optional feature macro: CMP_FLAGS_EN adds the registered {gt,eq,lt} flags port.
module cmp_iter_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             compout,
  output logic             op_err
`ifdef CMP_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOPIDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_badCfg
    $error("cmp_iter_unit: WIDTH must be a multiple of CHUNK");
  end

  cmp_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_signed;
  logic             r_illegal;
  logic [IDXW-1:0]  r_idx;

  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic             w_invertMsb;
  cmp_rel_t         w_rel;

  // Select the chunk pair currently pointed at by the index counter.
  always_comb begin
    w_aChunk = '0;
    w_bChunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_aChunk = r_a[i*CHUNK +: CHUNK];
        w_bChunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_invertMsb = r_signed && (r_idx == TOPIDX);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a          (w_aChunk),
    .b          (w_bChunk),
    .invert_msb (w_invertMsb),
    .rel        (w_rel)
  );

  // Request FSM with registered handshake and result outputs. An illegal op
  // still spends one RUN cycle so that its result appears one edge after
  // acceptance, the same as a compare decided on the top chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_signed  <= 1'b0;
      r_illegal <= 1'b0;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      compout   <= 1'b0;
      op_err    <= 1'b0;
`ifdef CMP_FLAGS_EN
      flags     <= 3'b000;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_op      <= op;
            r_signed  <= is_signed;
            r_illegal <= isIllegalOp(op);
            r_idx     <= TOPIDX;
            in_ready  <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (r_illegal) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            compout   <= 1'b0;
            op_err    <= 1'b1;
`ifdef CMP_FLAGS_EN
            flags     <= 3'b000;
`endif
          end else if ((w_rel != EQ) || (r_idx == '0)) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            compout   <= evalOp(r_op, w_rel);
            op_err    <= 1'b0;
`ifdef CMP_FLAGS_EN
            flags     <= relFlags(w_rel);
`endif
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            compout   <= 1'b0;
            op_err    <= 1'b0;
`ifdef CMP_FLAGS_EN
            flags     <= 3'b000;
`endif
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter_unit.sv
// Self-checking bench for cmp_iter_unit (WIDTH=32, CHUNK=8). Expected results
// come from an arithmetic model of the compare and of the early-exit latency.
module tb_cmp_iter_unit;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int MAXWAIT = 50;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             compout;
  logic             op_err;
  logic [2:0]       flags;

  int checks;
  int errors;

  cmp_iter_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .compout   (compout),
    .op_err    (op_err)
`ifdef CMP_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

`ifndef CMP_FLAGS_EN
  assign flags = 3'b000;
`endif

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Numeric value of an operand under the requested interpretation.
  function automatic longint refValue(input logic [WIDTH-1:0] v, input bit sg);
    if (sg) return longint'($signed(v));
    return longint'({32'b0, v});
  endfunction

  function automatic bit refResult(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                   input logic [2:0] rop, input bit sg);
    longint av;
    longint bv;
    av = refValue(ra, sg);
    bv = refValue(rb, sg);
    case (rop)
      3'd0: return av == bv;
      3'd1: return av >= bv;
      3'd2: return av <= bv;
      3'd3: return av >  bv;
      3'd4: return av <  bv;
      3'd5: return av != bv;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] refFlags(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                          input logic [2:0] rop, input bit sg);
    longint av;
    longint bv;
    if (rop[2:1] == 2'b11) return 3'b000;
    av = refValue(ra, sg);
    bv = refValue(rb, sg);
    return {av > bv, av == bv, av < bv};
  endfunction

  // Chunks examined: down to and including the first differing chunk from the top.
  function automatic int refLatency(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                    input logic [2:0] rop);
    if (rop[2:1] == 2'b11) return 1;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      if (ra[c*CHUNK +: CHUNK] != rb[c*CHUNK +: CHUNK]) return NCHUNK - c;
    end
    return NCHUNK;
  endfunction

  // Presents one request, scrambles the operands after acceptance and counts
  // edges until out_valid. Leaves the unit in DONE without a handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                               input logic [2:0] rop, input bit sg,
                               output int lat, output bit timedOut);
    @(negedge clk);
    in_valid  = 1'b1;
    a         = ra;
    b         = rb;
    op        = rop;
    is_signed = sg;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    op        = 3'($urandom_range(0, 7));
    is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    timedOut = 1'b1;
    for (int i = 0; i < MAXWAIT; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic doHandshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Runs one request and compares every result field against the model.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] ra,
                             input logic [WIDTH-1:0] rb, input logic [2:0] rop, input bit sg);
    int lat;
    bit timedOut;
    applyStimulus(ra, rb, rop, sg, lat, timedOut);
    checks++;
    if (timedOut) begin
      errors++;
      $display("[TB] FAIL %s timeout: out_valid never rose within %0d cycles", name, MAXWAIT);
      return;
    end
    checks++;
    if (lat !== refLatency(ra, rb, rop)) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, refLatency(ra, rb, rop));
    end
    checks++;
    if (compout !== refResult(ra, rb, rop, sg)) begin
      errors++;
      $display("[TB] FAIL %s compout: got %b expected %b (a=%h b=%h op=%b s=%b)",
               name, compout, refResult(ra, rb, rop, sg), ra, rb, rop, sg);
    end
    checks++;
    if (op_err !== (rop[2:1] == 2'b11)) begin
      errors++;
      $display("[TB] FAIL %s op_err: got %b expected %b", name, op_err, (rop[2:1] == 2'b11));
    end
`ifdef CMP_FLAGS_EN
    checks++;
    if (flags !== refFlags(ra, rb, rop, sg)) begin
      errors++;
      $display("[TB] FAIL %s flags: got %b expected %b", name, flags, refFlags(ra, rb, rop, sg));
    end
`endif
    doHandshake();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    is_signed = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, compout, op_err, flags} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b c=%b e=%b f=%b expected 1 0 0 0 000",
               in_ready, out_valid, compout, op_err, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    checkOutput("eq_full",      32'h12345678, 32'h12345678, 3'b000, 1'b0);
    checkOutput("gt_unsigned",  32'h80000000, 32'h00000001, 3'b011, 1'b0);
    checkOutput("gt_signed",    32'h80000000, 32'h00000001, 3'b011, 1'b1);
    checkOutput("lt_lowchunk",  32'h00FF0001, 32'h00FF0000, 3'b100, 1'b0);
    checkOutput("ne_lowchunk",  32'h00FF0001, 32'h00FF0000, 3'b101, 1'b0);
    checkOutput("illegal_110",  32'h00000005, 32'h00000005, 3'b110, 1'b0);
    checkOutput("illegal_111",  32'hFFFFFFFF, 32'h00000000, 3'b111, 1'b1);
    checkOutput("le_signed_neg",32'hFFFFFFFE, 32'h7FFFFFFF, 3'b010, 1'b1);
    checkOutput("ge_equal_sig", 32'h80000000, 32'h80000000, 3'b001, 1'b1);
  endtask

  // Random operands, biased so every early-exit depth gets exercised.
  task automatic test_random();
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] diff;
    int sel;
    for (int n = 0; n < 60; n++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        rb = ra;
      end else if (sel <= 4) begin
        diff = '0;
        diff[(sel-1)*CHUNK +: CHUNK] = 8'($urandom_range(1, 255));
        rb = ra ^ diff;
      end else begin
        rb = $urandom;
      end
      checkOutput("random", ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Result must hold under back-pressure and a new request must be ignored.
  task automatic test_back_to_back();
    int lat;
    bit timedOut;
    bit firstRes;
    applyStimulus(32'h0000_00A0, 32'h0000_00A0, 3'b000, 1'b0, lat, timedOut);
    firstRes = compout;
    checks++;
    if (timedOut || firstRes !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_first: got vld=%b c=%b expected vld=1 c=1", out_valid, compout);
    end
    @(negedge clk);
    in_valid = 1'b1;
    a  = 32'h1;
    b  = 32'h2;
    op = 3'b100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, compout, in_ready} !== {1'b1, firstRes, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b c=%b rdy=%b expected 1 %b 0",
                 i, out_valid, compout, in_ready, firstRes);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL after_handshake: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL ignored_req%0d: got vld=%b rdy=%b expected 0 1", i, out_valid, in_ready);
      end
    end
    checkOutput("after_b2b", 32'h1, 32'h2, 3'b100, 1'b0);
  endtask

  // Asynchronous reset mid-compare aborts with no leftover result.
  task automatic test_reset_in_run();
    @(negedge clk);
    in_valid = 1'b1;
    a  = 32'hCAFE0000;
    b  = 32'hCAFE0000;
    op = 3'b000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_in_run: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL stale_result%0d: got vld=%b rdy=%b expected 0 1", i, out_valid, in_ready);
      end
    end
    checkOutput("after_reset", 32'h00000010, 32'h00000020, 3'b010, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
